// File: rtl/dat_lookup_arbiter.sv
// Shares the DAT read port between indexed flow reads and IBI address scans; one read outstanding, round-robin on ties.
// Flow ack at read-valid+1; a scan costs num x (latency+2); requesters are held off by a level req until ack/done.
module dat_lookup_arbiter #(
    parameter int DatDepth = 128,
    parameter int DatAw    = $clog2(DatDepth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DatAw:0]   dat_num_entries_i,
    input  logic             flow_req_i,
    input  logic [DatAw-1:0] flow_idx_i,
    output logic             flow_ack_o,
    output logic             flow_err_o,
    output logic [63:0]      flow_entry_o,
    input  logic             ibi_req_i,
    input  logic [6:0]       ibi_addr_i,
    output logic             ibi_done_o,
    output logic             ibi_hit_o,
    output logic [DatAw-1:0] ibi_idx_o,
    output logic             ibi_reject_o,
    output logic             ibi_payload_o,
    output logic             dat_rd_req_o,
    output logic [DatAw-1:0] dat_rd_addr_o,
    input  logic             dat_rd_valid_i,
    input  logic [63:0]      dat_rd_data_i
);

    typedef enum logic [1:0] {IDLE, FLOW_WAIT, SCAN_ISSUE, SCAN_WAIT} state_t;
    typedef enum logic {GNT_FLOW, GNT_IBI} grant_t;

    localparam logic [DatAw:0] MaxNum = (DatAw+1)'(DatDepth);

    state_t           state;
    grant_t           last_grant;
    logic [6:0]       scan_addr;
    logic [DatAw:0]   num_q;
    logic [DatAw-1:0] cnt;
    logic [DatAw:0]   num_clamped;
    logic             grant_flow;
    logic             entry_hit;

    assign num_clamped = (dat_num_entries_i > MaxNum) ? MaxNum : dat_num_entries_i;
    assign grant_flow  = flow_req_i && (!ibi_req_i || last_grant == GNT_IBI);
    assign entry_hit   = !dat_rd_data_i[31] && (dat_rd_data_i[22:16] == scan_addr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            last_grant    <= GNT_IBI;
            scan_addr     <= '0;
            num_q         <= '0;
            cnt           <= '0;
            flow_ack_o    <= 1'b0;
            flow_err_o    <= 1'b0;
            flow_entry_o  <= '0;
            ibi_done_o    <= 1'b0;
            ibi_hit_o     <= 1'b0;
            ibi_idx_o     <= '0;
            ibi_reject_o  <= 1'b0;
            ibi_payload_o <= 1'b0;
            dat_rd_req_o  <= 1'b0;
            dat_rd_addr_o <= '0;
        end else begin
            flow_ack_o    <= 1'b0;
            flow_err_o    <= 1'b0;
            flow_entry_o  <= '0;
            ibi_done_o    <= 1'b0;
            ibi_hit_o     <= 1'b0;
            ibi_idx_o     <= '0;
            ibi_reject_o  <= 1'b0;
            ibi_payload_o <= 1'b0;
            dat_rd_req_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    // During the ack/done cycle the finishing requester still holds req; don't re-grant it.
                    if (!flow_ack_o && !ibi_done_o) begin
                        if (grant_flow) begin
                            last_grant <= GNT_FLOW;
                            if ({1'b0, flow_idx_i} >= num_clamped) begin
                                flow_ack_o <= 1'b1;
                                flow_err_o <= 1'b1;
                            end else begin
                                dat_rd_req_o  <= 1'b1;
                                dat_rd_addr_o <= flow_idx_i;
                                state         <= FLOW_WAIT;
                            end
                        end else if (ibi_req_i) begin
                            last_grant <= GNT_IBI;
                            scan_addr  <= ibi_addr_i;
                            num_q      <= num_clamped;
                            cnt        <= '0;
                            if (num_clamped == '0) begin
                                ibi_done_o <= 1'b1;
                            end else begin
                                state <= SCAN_ISSUE;
                            end
                        end
                    end
                end
                FLOW_WAIT: begin
                    if (dat_rd_valid_i) begin
                        flow_ack_o   <= 1'b1;
                        flow_entry_o <= dat_rd_data_i;
                        state        <= IDLE;
                    end
                end
                SCAN_ISSUE: begin
                    dat_rd_req_o  <= 1'b1;
                    dat_rd_addr_o <= cnt;
                    state         <= SCAN_WAIT;
                end
                SCAN_WAIT: begin
                    if (dat_rd_valid_i) begin
                        if (entry_hit) begin
                            ibi_done_o    <= 1'b1;
                            ibi_hit_o     <= 1'b1;
                            ibi_idx_o     <= cnt;
                            ibi_reject_o  <= dat_rd_data_i[13];
                            ibi_payload_o <= dat_rd_data_i[12];
                            state         <= IDLE;
                        end else if ({1'b0, cnt} == num_q - 1'b1) begin
                            ibi_done_o <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= SCAN_ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
